if_fetch_stage: RTL and testbench



---
 rtl/if_fetch_if.sv | 28 ++
 rtl/if_fetch_stage.sv | 70 +++++++
 tb/tb_if_fetch_stage.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/if_fetch_if.sv
// Bundle between the fetch stage and its environment: run/flush/stall/redirect
// control, the synchronous instruction-memory port and the decode-side outputs.
interface if_fetch_if #(
  parameter int IMEM_AW = 12
);
  logic               cpu_run;
  logic               rst_pipe;
  logic               stall;
  logic               jmp_req_ex;
  logic [29:0]        jmp_adr_ex;
  logic [IMEM_AW-1:0] imem_radr;
  logic [31:0]        imem_rdata;
  logic [31:0]        inst_id;
  logic [29:0]        pc_id;
  logic               inst_vld_id;

  // Fetch stage side.
  modport master (
    input  cpu_run, rst_pipe, stall, jmp_req_ex, jmp_adr_ex, imem_rdata,
    output imem_radr, inst_id, pc_id, inst_vld_id
  );

  // Controller, memory and decode side.
  modport slave (
    output cpu_run, rst_pipe, stall, jmp_req_ex, jmp_adr_ex, imem_rdata,
    input  imem_radr, inst_id, pc_id, inst_vld_id
  );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: owns the PC, drives the synchronous instruction memory
// and feeds decode. Define IF_FETCH_CNT_EN to add the fetch_cnt consumed-instruction counter.
module if_fetch_stage #(
  parameter logic [29:0] START_ADR = 30'h0000_0000,
  parameter int          IMEM_AW   = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  if_fetch_if.master  fif
`ifdef IF_FETCH_CNT_EN
  ,
  output logic [31:0] fetch_cnt
`endif
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [29:0] pc_id_q;
  logic        vld_q;
  logic [29:0] pc_sel;
  logic        vld_d;

  // Next PC; the memory address is taken from it so read data lines up with pc_id next cycle.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    pc_sel = pc_id_q;
    if (!rst_n)              pc_sel = START_ADR;
    else if (fif.rst_pipe)   pc_sel = START_ADR;
    else if (fif.jmp_req_ex) pc_sel = fif.jmp_adr_ex;
    else if (fif.stall)      pc_sel = pc_id_q;
    else if (vld_q)          pc_sel = pc_id_q + 30'd1;
  end

  always_comb begin
    vld_d = fif.cpu_run;
    if (fif.rst_pipe)        vld_d = 1'b0;
    else if (fif.jmp_req_ex) vld_d = fif.cpu_run;
    else if (fif.stall)      vld_d = vld_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      pc_id_q <= START_ADR;
      vld_q   <= 1'b0;
    end else begin
      pc_id_q <= pc_sel;
      vld_q   <= vld_d;
    end
  end

  assign fif.imem_radr   = pc_sel[IMEM_AW-1:0];
  assign fif.inst_id     = vld_q ? fif.imem_rdata : NOP;
  assign fif.pc_id       = pc_id_q;
  assign fif.inst_vld_id = vld_q;

`ifdef IF_FETCH_CNT_EN
  logic [31:0] fetch_cnt_q;

  // Counts instructions actually consumed by decode: valid and not stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    fetch_cnt_q <= '0;
    else if (fif.rst_pipe)         fetch_cnt_q <= '0;
    else if (vld_q && !fif.stall)  fetch_cnt_q <= fetch_cnt_q + 32'd1;
  end

  assign fetch_cnt = fetch_cnt_q;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Scoreboard bench for if_fetch_stage: directed per-cycle vectors push expected
// pc/vld/address into a queue; a negedge monitor pops and compares.
module tb_if_fetch_stage;

  localparam int          AW  = 12;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    logic [29:0] pc;
    logic        vld;
    logic [29:0] sel;
    logic        cc;
    logic [31:0] cnt;
  } exp_t;

  logic clk;
  logic rst_n;
  logic [31:0] imem [0:(1<<AW)-1];
  exp_t sb[$];
  int n_checks;
  int n_pass;
  int n_vec;

  if_fetch_if #(.IMEM_AW(AW)) fif ();

`ifdef IF_FETCH_CNT_EN
  logic [31:0] fetch_cnt;
`endif

  if_fetch_stage #(.START_ADR(30'h0), .IMEM_AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .fif   (fif)
`ifdef IF_FETCH_CNT_EN
    ,
    .fetch_cnt (fetch_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory content model: word at address a is C0DE_0aaa.
  function automatic logic [31:0] mem_word(input logic [29:0] pc);
    return {16'hC0DE, 4'h0, pc[AW-1:0]};
  endfunction

  always @(posedge clk) fif.imem_rdata <= imem[fif.imem_radr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s vec %0d: got %h expected %h", name, n_vec, act, exp);
  endtask

  // Monitor: every cycle the DUT presents pc/inst/vld/address; compare against the queue.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check("pc_id", {2'b00, fif.pc_id}, {2'b00, e.pc});
      check("inst_vld_id", {31'b0, fif.inst_vld_id}, {31'b0, e.vld});
      check("inst_id", fif.inst_id, e.vld ? mem_word(e.pc) : NOP);
      check("imem_radr", {20'b0, fif.imem_radr}, {20'b0, e.sel[AW-1:0]});
`ifdef IF_FETCH_CNT_EN
      if (e.cc) check("fetch_cnt", fetch_cnt, e.cnt);
`endif
      n_vec++;
    end
  end

  // One cycle: apply inputs just after the edge and queue what the monitor must see this cycle.
  task automatic step(input int rstn, input int run, input int rp, input int st,
                      input int jr, input int ja,
                      input int e_pc, input int e_vld, input int e_sel,
                      input int cc = 0, input int e_cnt = 0);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n          = (rstn != 0);
    fif.cpu_run    = (run != 0);
    fif.rst_pipe   = (rp != 0);
    fif.stall      = (st != 0);
    fif.jmp_req_ex = (jr != 0);
    fif.jmp_adr_ex = 30'(ja);
    e.pc  = 30'(e_pc);
    e.vld = (e_vld != 0);
    e.sel = 30'(e_sel);
    e.cc  = (cc != 0);
    e.cnt = 32'(e_cnt);
    sb.push_back(e);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    n_vec    = 0;
    for (int i = 0; i < (1 << AW); i++) imem[i] = mem_word(30'(i));
    rst_n          = 1'b0;
    fif.cpu_run    = 1'b0;
    fif.rst_pipe   = 1'b0;
    fif.stall      = 1'b0;
    fif.jmp_req_ex = 1'b0;
    fif.jmp_adr_ex = '0;

    //   rstn run rp st jr ja            pc           vld sel          cc cnt
    step(0, 0, 0, 0, 0, 0,             0,           0, 0,            1, 0);
    step(0, 0, 0, 0, 1, 'h55,          0,           0, 0,            1, 0);
    // Boot, cpu_run low
    for (int i = 0; i < 5; i++)
      step(1, 0, 0, 0, 0, 0,           0,           0, 0,            1, 0);
    step(1, 1, 0, 0, 0, 0,             0,           0, 0,            1, 0);
    step(1, 1, 0, 0, 0, 0,             0,           1, 1);
    step(1, 1, 0, 0, 0, 0,             1,           1, 2);
    // Stall at pc 2
    for (int i = 0; i < 3; i++)
      step(1, 1, 0, 1, 0, 0,           2,           1, 2);
    step(1, 1, 0, 0, 0, 0,             2,           1, 3);
    // Jump beats stall
    step(1, 1, 0, 1, 1, 'h40,          3,           1, 'h40);
    step(1, 1, 0, 0, 0, 0,             'h40,        1, 'h41);
    step(1, 1, 0, 0, 1, 'h10,          'h41,        1, 'h10);
    // rst_pipe beats jump
    step(1, 1, 1, 0, 1, 'h77,          'h10,        1, 0);
    step(1, 1, 0, 0, 0, 0,             0,           0, 0);
    for (int i = 0; i < 5; i++)
      step(1, 1, 0, 0, 0, 0,           i,           1, i + 1);
    // Stop while showing (5,F), then resume at 6
    step(1, 0, 0, 0, 0, 0,             5,           1, 6);
    step(1, 0, 0, 0, 0, 0,             6,           0, 6);
    step(1, 1, 0, 0, 0, 0,             6,           0, 6);
    step(1, 1, 0, 0, 0, 0,             6,           1, 7);
    // cpu_run ignored under stall
    step(1, 0, 0, 1, 0, 0,             7,           1, 7);
    step(1, 0, 0, 0, 0, 0,             7,           1, 8);
    step(1, 0, 0, 0, 0, 0,             8,           0, 8);
    // Jump while stopped: vld follows cpu_run
    step(1, 0, 0, 0, 1, 'h20,          8,           0, 'h20);
    step(1, 1, 0, 0, 0, 0,             'h20,        0, 'h20);
    step(1, 1, 0, 0, 0, 0,             'h20,        1, 'h21);
    // PC wrap
    step(1, 1, 0, 0, 1, 'h3FFF_FFFF,   'h21,        1, 'h3FFF_FFFF);
    step(1, 1, 0, 0, 0, 0,             'h3FFF_FFFF, 1, 0);
    // Flush, then 10 consumed + 3 stalled for the fetch counter
    step(1, 1, 1, 0, 0, 0,             0,           1, 0);
    step(1, 1, 0, 0, 0, 0,             0,           0, 0,            1, 0);
    for (int i = 0; i < 5; i++)
      step(1, 1, 0, 0, 0, 0,           i,           1, i + 1,        1, i);
    for (int i = 0; i < 3; i++)
      step(1, 1, 0, 1, 0, 0,           5,           1, 5,            1, 5);
    for (int i = 5; i < 10; i++)
      step(1, 1, 0, 0, 0, 0,           i,           1, i + 1,        1, i);
    step(1, 0, 0, 1, 0, 0,             10,          1, 10,           1, 10);
    step(1, 0, 0, 0, 0, 0,             10,          1, 11,           1, 10);
    step(1, 0, 0, 0, 0, 0,             11,          0, 11,           1, 11);
    // Asynchronous reset mid-run
    step(0, 1, 0, 0, 1, 'h55,          0,           0, 0,            1, 0);
    step(0, 1, 0, 0, 0, 0,             0,           0, 0,            1, 0);
    step(1, 1, 0, 0, 0, 0,             0,           0, 0,            1, 0);
    step(1, 1, 0, 0, 0, 0,             0,           1, 1,            1, 0);

    @(negedge clk);
    @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
